// File: rtl/fp8_dot_sequencer.sv
// Sequences an FP8 dot product over two local operand buffers into a downstream MAC,
// then captures the MAC's FP16 accumulator. All outputs are registered.
module fp8_dot_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WAIT_MAX = 8,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   result,
  output logic [7:0]    mac_operand_a,
  output logic [7:0]    mac_operand_b,
  output logic          mac_enable,
  output logic          mac_clear,
  input  logic          mac_valid,
  input  logic [15:0]   mac_accumulator
);

  localparam int unsigned WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {StIdle, StClear, StIssue, StWait, StDone} state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   idx_q, idx_d;
  logic [WW-1:0] wait_q, wait_d;

  logic          busy_d, done_d, err_d, en_d, clr_d;
  logic [15:0]   result_d;
  logic [7:0]    op_a_d, op_b_d;
  logic          len_ok;

  assign len_ok = (len != '0) && (len <= (AW+1)'(DEPTH));

  // Operand buffers are not reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    err_d    = err;
    result_d = result;
    op_a_d   = '0;
    op_b_d   = '0;
    en_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            len_d   = len;
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = StClear;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      // idx_q counts issued pairs; it can reach DEPTH, hence the extra bit.
      StClear, StIssue: begin
        if (idx_q == len_q) begin
          wait_d  = '0;
          state_d = StWait;
        end else begin
          en_d    = 1'b1;
          op_a_d  = mem_a[idx_q[AW-1:0]];
          op_b_d  = mem_b[idx_q[AW-1:0]];
          idx_d   = idx_q + 1'b1;
          state_d = StIssue;
        end
      end
      StWait: begin
        if (mac_valid) begin
          result_d = mac_accumulator;
          state_d  = StDone;
        end else if (wait_q == WW'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    clr_d  = (state_d == StClear);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      len_q         <= '0;
      idx_q         <= '0;
      wait_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      result        <= 16'h0000;
      mac_operand_a <= '0;
      mac_operand_b <= '0;
      mac_enable    <= 1'b0;
      mac_clear     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      result        <= result_d;
      mac_operand_a <= op_a_d;
      mac_operand_b <= op_b_d;
      mac_enable    <= en_d;
      mac_clear     <= clr_d;
    end
  end

endmodule

// File: tb/tb_fp8_dot_sequencer.sv
// Randomised bench for fp8_dot_sequencer: a transaction-level schedule model drives expectations
// that one compare process checks every cycle; a real-valued MAC model pins directed results.
module tb_fp8_dot_sequencer;
  localparam int DEPTH    = 16;
  localparam int WAIT_MAX = 8;
  localparam int AW       = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          busy, done, err;
  logic [15:0]   result;
  logic [7:0]    mac_operand_a, mac_operand_b;
  logic          mac_enable, mac_clear;
  logic          mac_valid = 1'b0;
  logic [15:0]   mac_accumulator = '0;

  fp8_dot_sequencer #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .len(len), .busy(busy), .done(done), .err(err),
    .result(result), .mac_operand_a(mac_operand_a), .mac_operand_b(mac_operand_b),
    .mac_enable(mac_enable), .mac_clear(mac_clear), .mac_valid(mac_valid),
    .mac_accumulator(mac_accumulator)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done, err;
    logic [15:0] res;
    logic [7:0] a, b;
    logic en, clr;
  } exp_t;

  exp_t ex;
  bit   chk_on = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   n_en = 0, n_clr = 0, n_done = 0;
  int   b_en = 0, b_clr = 0, b_done = 0;
  bit   pin_on = 1'b0;
  logic [15:0] pin_res = '0;
  logic pin_err = 1'b0;
  int   pin_en = 0, pin_clr = 0, pin_done = 0;

  logic [7:0]  ma [DEPTH];
  logic [7:0]  mb [DEPTH];
  logic        m_err = 1'b0;
  logic [15:0] m_res = '0;
  real         mac_sum = 0.0;

  function automatic exp_t mk(input logic bz, dn, er, input logic [15:0] r,
                              input logic [7:0] a, b, input logic en, clr);
    exp_t e;
    e.busy = bz; e.done = dn; e.err = er; e.res = r;
    e.a = a; e.b = b; e.en = en; e.clr = clr;
    return e;
  endfunction

  function automatic real dec(input logic [7:0] v);
    int  e = int'(v[6:3]);
    int  m = int'(v[2:0]);
    real x = (e == 0) ? real'(m) / 8.0 : 1.0 + real'(m) / 8.0;
    int  p = (e == 0) ? -6 : e - 7;
    while (p > 0) begin x = x * 2.0; p--; end
    while (p < 0) begin x = x / 2.0; p++; end
    return v[7] ? -x : x;
  endfunction

  function automatic logic [15:0] enc(input real v);
    real  x;
    int   e, m;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    x = s ? -v : v;
    e = 15;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0) begin x = x * 2.0; e--; end
    m = int'($floor((x - 1.0) * 1024.0));
    return {s, 5'(e), 10'(m)};
  endfunction

  // Behavioural MAC: clear on mac_clear, accumulate exact products on mac_enable.
  always @(posedge clk) begin
    if (mac_clear) mac_sum <= 0.0;
    else if (mac_enable) mac_sum <= mac_sum + dec(mac_operand_a) * dec(mac_operand_b);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 16'(busy), 16'(ex.busy));
      chk("done", 16'(done), 16'(ex.done));
      chk("err", 16'(err), 16'(ex.err));
      chk("result", result, ex.res);
      chk("mac_operand_a", 16'(mac_operand_a), 16'(ex.a));
      chk("mac_operand_b", 16'(mac_operand_b), 16'(ex.b));
      chk("mac_enable", 16'(mac_enable), 16'(ex.en));
      chk("mac_clear", 16'(mac_clear), 16'(ex.clr));
      if (pin_on) begin
        chk("pin_result", result, pin_res);
        chk("pin_err", 16'(err), 16'(pin_err));
        chk("pin_enable_count", 16'(n_en - b_en), 16'(pin_en));
        chk("pin_clear_count", 16'(n_clr - b_clr), 16'(pin_clr));
        chk("pin_done_count", 16'(n_done - b_done), 16'(pin_done));
      end
      n_en   += int'(mac_enable);
      n_clr  += int'(mac_clear);
      n_done += int'(done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit on);
    start           = on ? 1'($urandom) : 1'b0;
    len             = 5'($urandom);
    wr_en           = on ? 1'($urandom) : 1'b0;
    wr_sel          = 1'($urandom);
    wr_addr         = 4'($urandom);
    wr_data         = 8'($urandom);
    mac_valid       = on ? 1'($urandom) : 1'b0;
    mac_accumulator = 16'($urandom);
  endtask

  task automatic snap();
    b_en = n_en; b_clr = n_clr; b_done = n_done;
  endtask

  task automatic pin(input logic [15:0] r, input logic e, input int en, clr, dn);
    pin_res = r; pin_err = e; pin_en = en; pin_clr = clr; pin_done = dn;
    pin_on = 1'b1;
    @(negedge clk);
    #1;
    pin_on = 1'b0;
  endtask

  task automatic write(input logic sel, input int addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
  endtask

  // vdly: WAIT cycle (1..WAIT_MAX) on which mac_valid rises, 0 = never.
  task automatic run_op(input int l, input int vdly, input bit nz, input bit use_mac);
    logic [15:0] acc;
    start = 1'b1;
    len   = 5'(l);
    tick();
    if (l < 1 || l > DEPTH) begin
      m_err = 1'b1;
      ex = mk(1, 1, 1, m_res, 0, 0, 0, 0);
      noise(nz);
      tick();
      ex = mk(0, 0, m_err, m_res, 0, 0, 0, 0);
      noise(0);
      return;
    end
    m_err = 1'b0;
    ex = mk(1, 0, 0, m_res, 0, 0, 0, 1);
    noise(nz);
    for (int i = 0; i < l; i++) begin
      tick();
      ex = mk(1, 0, 0, m_res, ma[i], mb[i], 1, 0);
      noise(nz);
    end
    tick();
    for (int k = 1; k <= WAIT_MAX; k++) begin
      ex = mk(1, 0, 0, m_res, 0, 0, 0, 0);
      noise(nz);
      acc             = use_mac ? enc(mac_sum) : 16'($urandom);
      mac_valid       = (k == vdly);
      mac_accumulator = acc;
      tick();
      if (k == vdly) begin
        m_res = acc;
        break;
      end
      if (k == WAIT_MAX) m_err = 1'b1;
    end
    ex = mk(1, 1, m_err, m_res, 0, 0, 0, 0);
    noise(nz);
    tick();
    ex = mk(0, 0, m_err, m_res, 0, 0, 0, 0);
    noise(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    noise(0);
    rst_n = 1'b0;
    tick();
    ex = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      write(0, i, 8'($urandom));
      write(1, i, 8'($urandom));
    end

    // 1.0 * 2.0 over four elements = 8.0
    for (int i = 0; i < 4; i++) begin
      write(0, i, 8'h38);
      write(1, i, 8'h40);
    end
    snap(); run_op(4, 1, 0, 1); pin(16'h4800, 0, 4, 1, 1);

    snap(); run_op(0, 1, 0, 1);  pin(16'h4800, 1, 0, 0, 1);
    snap(); run_op(17, 1, 0, 1); pin(16'h4800, 1, 0, 0, 1);

    snap(); run_op(4, 0, 0, 1); pin(16'h4800, 1, 4, 1, 1);
    snap(); run_op(4, 1, 0, 1); pin(16'h4800, 0, 4, 1, 1);

    // start/wr_en noise while busy must not disturb the run
    snap(); run_op(4, 3, 1, 1); pin(16'h4800, 0, 4, 1, 1);

    // same-cycle write to A[0] = 2.0 with start: 2*2 + 3*(1*2) = 10.0
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'h40;
    ma[0] = 8'h40;
    snap(); run_op(4, 1, 0, 1); pin(16'h4900, 0, 4, 1, 1);

    // reset during ISSUE
    snap();
    start = 1'b1; len = 5'd8;
    tick(); ex = mk(1, 0, 0, m_res, 0, 0, 0, 1); start = 1'b0;
    tick(); ex = mk(1, 0, 0, m_res, ma[0], mb[0], 1, 0);
    tick(); ex = mk(1, 0, 0, m_res, ma[1], mb[1], 1, 0);
    rst_n = 1'b0;
    tick(); m_res = '0; m_err = 1'b0; ex = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    pin(16'h0000, 0, 2, 1, 0);

    // full buffer: A alternates 1.0/2.0, B = 1.0, sum = 24.0
    for (int i = 0; i < DEPTH; i++) begin
      write(0, i, (i % 2 == 1) ? 8'h40 : 8'h38);
      write(1, i, 8'h38);
    end
    snap(); run_op(16, 2, 0, 1); pin(16'h4E00, 0, 16, 1, 1);

    for (int n = 0; n < 30; n++) begin
      for (int w = 0; w < 4; w++) write(1'($urandom), $urandom_range(0, DEPTH - 1), 8'($urandom));
      run_op($urandom_range(0, DEPTH + 2), $urandom_range(0, WAIT_MAX), 1'($urandom), 1'b0);
      tick();
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
